jtopl_eg_state: RTL
===================

JTOPL_EG_STATE -- requirements
Module: jtopl_eg_state

Purpose: per-slot envelope state store and key edge detector. Feeds the combinational envelope stage (state_in, eg_in, keyon_now, keyoff_now, eg_cnt) and captures its results (state_next, eg_next) for the same slot.

Interface
REQ-001 SHALL have parameter SLOTS, default 18, number of time-multiplexed operator slots.
REQ-002 SHALL have parameter CNTW, default 15, envelope counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port cen, input, 1, clock enable; one slot processed per cen-high cycle.
REQ-006 SHALL have port kon, input, 1, key-on register bit of the current slot.
REQ-007 SHALL have port state_next, input, 3, next envelope state from the combinational stage.
REQ-008 SHALL have port eg_next, input, 10, next attenuation from the combinational stage.
REQ-009 SHALL have port slot, output, 5, index of the current slot.
REQ-010 SHALL have port zero, output, 1, high while slot==0.
REQ-011 SHALL have port keyon_now, output, 1, rising key edge for the current slot.
REQ-012 SHALL have port keyoff_now, output, 1, falling key edge for the current slot.
REQ-013 SHALL have port state_in, output, 3, stored envelope state of the current slot.
REQ-014 SHALL have port eg_in, output, 10, stored attenuation of the current slot.
REQ-015 SHALL have port eg_cnt, output, CNTW, global envelope counter.

Function
REQ-016 slot SHALL advance by 1 on each clk edge with cen=1, wrapping SLOTS-1 -> 0; with cen=0 it SHALL hold.
REQ-017 Per-slot storage SHALL hold state (3b), attenuation (10b) and previous key bit (1b) for every slot.
REQ-018 state_in and eg_in SHALL present the stored values of the current slot combinationally, with no added latency.
REQ-019 keyon_now SHALL equal kon & ~kon_prev[slot]; keyoff_now SHALL equal ~kon & kon_prev[slot]; they are never high together.
REQ-020 On a cen edge, state_next, eg_next and kon SHALL be written into the current slot's storage. Write-back latency is one cycle, and the slot is next read SLOTS cen cycles later.
REQ-021 The stored state SHALL be one of these encodings, defined in the package: ATTACK=3'b001, DECAY=3'b010, HOLD=3'b100, RELEASE=3'b000.
REQ-022 eg_cnt SHALL increment by 1 on the cen edge where slot==SLOTS-1, and wrap from all-ones to 0.
REQ-023 With cen=0, no storage, counter or slot state SHALL change; outputs SHALL remain consistent with the held slot.
REQ-024 If kon toggles between cen cycles, only the value present at a cen edge SHALL be sampled; glitches between edges SHALL be ignored.

Reset
REQ-025 On rst=1 at a clk edge, regardless of cen:
- slot=0, eg_cnt=0
- every slot: state=RELEASE, attenuation=10'h3FF, kon_prev=0
REQ-026 While rst=1, outputs SHALL read slot=0, zero=1, state_in=RELEASE, eg_in=10'h3FF, keyon_now=kon, keyoff_now=0.
REQ-027 Reset asserted mid-cycle through the slots SHALL discard all pending write-backs; the first cen edge after release SHALL process slot 0.

Configuration
REQ-028 Macro JTOPL_EG_MUTE_EN defined: adds input mute, width SLOTS. When mute[slot]=1 at a cen edge, write-back SHALL force attenuation 10'h3FF and state RELEASE; kon_prev SHALL still be updated.
REQ-029 Macro undefined: the mute port SHALL be absent and write-back SHALL be unconditional per REQ-020.

Structure
REQ-030 Package jtopl_eg_pkg SHALL hold the state encodings, the EG_MAX=10'h3FF constant and the default SLOTS value.
REQ-031 Slot counting and the zero flag SHALL live in sub-module jtopl_slot_cnt; storage and edge detection SHALL stay in the top module.

Verification
REQ-032 Reset then 18 cen cycles -> every slot reads state_in=3'b000 and eg_in=10'h3FF; eg_cnt=1 after the 18th edge.
REQ-033 kon=1 on slot 5 only, first pass -> keyon_now=1 at slot 5 only; second pass with kon=1 -> keyon_now=0.
REQ-034 Slot 5: kon 1 then 0 on the next pass -> keyoff_now=1 at slot 5 for one cycle; keyon_now=0.
REQ-035 Write state_next=3'b001, eg_next=10'h155 at slot 7 -> exactly 18 cen edges later state_in=3'b001, eg_in=10'h155 at slot 7; other slots are unchanged.
REQ-036 cen low for 10 cycles mid-pass at slot 9 -> slot stays 9 and the storage is unchanged; the following cen advances to slot 10.
REQ-037 Preload eg_cnt=15'h7FFF, then complete one slot pass -> eg_cnt=0. With JTOPL_EG_MUTE_EN and mute[3]=1, writing eg_next=0 at slot 3 -> reads back 10'h3FF.

Source files
------------

// File: rtl/jtopl_eg_pkg.sv
// Shared constants for the envelope state store: state encodings, attenuation ceiling and
// the default slot count.
package jtopl_eg_pkg;

    localparam int unsigned SLOTS_DEF = 18;
    localparam logic [9:0]  EG_MAX    = 10'h3FF;

    typedef enum logic [2:0] {
        Release = 3'b000,
        Attack  = 3'b001,
        Decay   = 3'b010,
        Hold    = 3'b100
    } eg_state_e;

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Time-multiplexed slot counter: advances once per cen cycle, wraps at SLOTS-1, and flags
// the first and last slot of each pass.
module jtopl_slot_cnt
    import jtopl_eg_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    output logic [4:0] slot,
    output logic       zero,
    output logic       last
);

    localparam logic [4:0] SlotLast = 5'(SLOTS - 1);

    logic [4:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (cen) begin
            slot_d = (slot_q == SlotLast) ? 5'd0 : slot_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= 5'd0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Forced to 0 during reset so outputs are defined before the first reset edge.
    assign slot = rst ? 5'd0 : slot_q;
    assign zero = (slot == 5'd0);
    assign last = (slot == SlotLast);

endmodule

// File: rtl/jtopl_eg_state.sv
// Per-slot envelope state/attenuation store with key edge detection and global EG counter.
// Optional JTOPL_EG_MUTE_EN adds a per-slot mute input forcing release at full attenuation.
module jtopl_eg_state
    import jtopl_eg_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF,
    parameter int unsigned CNTW  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            kon,
    input  logic [2:0]      state_next,
    input  logic [9:0]      eg_next,
`ifdef JTOPL_EG_MUTE_EN
    input  logic [SLOTS-1:0] mute,
`endif
    output logic [4:0]      slot,
    output logic            zero,
    output logic            keyon_now,
    output logic            keyoff_now,
    output logic [2:0]      state_in,
    output logic [9:0]      eg_in,
    output logic [CNTW-1:0] eg_cnt
);

    logic            last;
    logic [2:0]      state_q    [SLOTS];
    logic [2:0]      state_d    [SLOTS];
    logic [9:0]      eg_q       [SLOTS];
    logic [9:0]      eg_d       [SLOTS];
    logic            kon_prev_q [SLOTS];
    logic            kon_prev_d [SLOTS];
    logic [CNTW-1:0] eg_cnt_q, eg_cnt_d;
    logic            kon_prev;
    logic [2:0]      wr_state;
    logic [9:0]      wr_eg;

    jtopl_slot_cnt #(
        .SLOTS (SLOTS)
    ) u_slot_cnt (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .slot (slot),
        .zero (zero),
        .last (last)
    );

    // Reads bypass storage during reset so the reset image is visible immediately.
    assign kon_prev   = rst ? 1'b0 : kon_prev_q[slot];
    assign state_in   = rst ? 3'(Release) : state_q[slot];
    assign eg_in      = rst ? EG_MAX : eg_q[slot];
    assign keyon_now  = kon & ~kon_prev;
    assign keyoff_now = ~kon & kon_prev;
    assign eg_cnt     = eg_cnt_q;

    always_comb begin
        wr_state = state_next;
        wr_eg    = eg_next;
`ifdef JTOPL_EG_MUTE_EN
        if (mute[slot]) begin
            wr_state = 3'(Release);
            wr_eg    = EG_MAX;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        eg_d       = eg_q;
        kon_prev_d = kon_prev_q;
        eg_cnt_d   = eg_cnt_q;
        if (cen) begin
            state_d[slot]    = wr_state;
            eg_d[slot]       = wr_eg;
            kon_prev_d[slot] = kon;
            if (last) begin
                eg_cnt_d = eg_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                state_q[i]    <= 3'(Release);
                eg_q[i]       <= EG_MAX;
                kon_prev_q[i] <= 1'b0;
            end
            eg_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            eg_q       <= eg_d;
            kon_prev_q <= kon_prev_d;
            eg_cnt_q   <= eg_cnt_d;
        end
    end

endmodule
